// File: rtl/platform_field.sv
// Platform store for the playfield: LFSR-driven layout, downward scroll with
// wrap-to-top regeneration, and registered pixel / landing hit queries.
module platform_field #(
  parameter int         N_PLAT    = 16,
  parameter int         HALF_W    = 4,
  parameter int         HALF_H    = 4,
  parameter int         SPACING   = 30,
  parameter int         SCREEN_H  = 480,
  parameter int         X_MIN     = 64,
  parameter logic [9:0] LFSR_SEED = 10'h1A5
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      load_req,
  input  logic                      scroll_req,
  input  logic [3:0]                scroll_amt,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic [9:0]                BallX,
  input  logic [9:0]                BallY,
  input  logic [9:0]                Ball_size,
  output logic                      busy,
  output logic                      pix_on,
  output logic [$clog2(N_PLAT)-1:0] pix_idx,
  output logic                      ball_land,
  output logic [$clog2(N_PLAT)-1:0] land_idx
);
  localparam int IW = $clog2(N_PLAT);
  localparam logic signed [11:0] HW = 12'(HALF_W);
  localparam logic signed [11:0] HH = 12'(HALF_H);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCROLL} state_t;

  state_t        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [3:0]    amt_q, amt_d;
  logic [9:0]    lfsr_q, lfsr_d;
  logic [9:0]    plat_x_q [N_PLAT];
  logic [9:0]    plat_x_d [N_PLAT];
  logic [9:0]    plat_y_q [N_PLAT];
  logic [9:0]    plat_y_d [N_PLAT];
  logic [9:0]    rand_x;
  logic          last_idx;
  logic          pix_on_q, pix_on_d, ball_land_q, ball_land_d;
  logic [IW-1:0] pix_idx_q, pix_idx_d, land_idx_q, land_idx_d;
  logic [N_PLAT-1:0] pix_hit, land_hit;
  logic signed [11:0] draw_x_s, draw_y_s, ball_x_s, ball_bot_s, ball_sz_s;

  assign lfsr_d   = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
  assign rand_x   = 10'(X_MIN) + {1'b0, lfsr_q[8:0]};
  assign last_idx = (idx_q == 5'(N_PLAT - 1));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      amt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      amt_q   <= amt_d;
    end
  end

  // Requests are only looked at in IDLE, so anything arriving while busy is dropped.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    amt_d   = amt_q;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (load_req) begin
          state_d = S_LOAD;
        end else if (scroll_req) begin
          state_d = S_SCROLL;
          amt_d   = scroll_amt;
        end
      end
      default: begin
        idx_d = last_idx ? 5'd0 : idx_q + 5'd1;
        if (last_idx) state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  always_comb begin
    logic [10:0] ny;
    ny = '0;
    for (int i = 0; i < N_PLAT; i++) begin
      plat_x_d[i] = plat_x_q[i];
      plat_y_d[i] = plat_y_q[i];
      ny = {1'b0, plat_y_q[i]} + {7'd0, amt_q};
      if (idx_q == 5'(i)) begin
        if (state_q == S_LOAD) begin
          plat_x_d[i] = rand_x;
          plat_y_d[i] = 10'((i + 1) * SPACING);
        end else if (state_q == S_SCROLL) begin
          if (ny >= 11'(SCREEN_H)) begin
            plat_y_d[i] = 10'(ny - 11'(SCREEN_H));
            plat_x_d[i] = rand_x;
          end else begin
            plat_y_d[i] = ny[9:0];
          end
        end
      end
    end
  end

  // Widened signed compares keep platY < HALF_H from wrapping to the bottom of the screen.
  assign draw_x_s   = signed'({2'b00, DrawX});
  assign draw_y_s   = signed'({2'b00, DrawY});
  assign ball_x_s   = signed'({2'b00, BallX});
  assign ball_sz_s  = signed'({2'b00, Ball_size});
  assign ball_bot_s = signed'({2'b00, BallY} + {2'b00, Ball_size});

  generate
    for (genvar gi = 0; gi < N_PLAT; gi++) begin : g_hit
      logic signed [11:0] px, py, ddx, adx;
      assign px  = signed'({2'b00, plat_x_q[gi]});
      assign py  = signed'({2'b00, plat_y_q[gi]});
      assign ddx = ball_x_s - px;
      assign adx = (ddx < 0) ? -ddx : ddx;
      assign pix_hit[gi]  = (draw_x_s >= px - HW) && (draw_x_s <= px + HW) &&
                            (draw_y_s >= py - HH) && (draw_y_s <= py + HH);
      assign land_hit[gi] = (ball_bot_s >= py - HH) && (ball_bot_s <= py + HH) &&
                            (adx <= HW + ball_sz_s);
    end
  endgenerate

  always_comb begin
    pix_on_d    = |pix_hit;
    ball_land_d = |land_hit;
    pix_idx_d   = '0;
    land_idx_d  = '0;
    for (int i = N_PLAT - 1; i >= 0; i--) begin
      if (pix_hit[i])  pix_idx_d  = IW'(i);
      if (land_hit[i]) land_idx_d = IW'(i);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      lfsr_q      <= LFSR_SEED;
      pix_on_q    <= 1'b0;
      pix_idx_q   <= '0;
      ball_land_q <= 1'b0;
      land_idx_q  <= '0;
      for (int i = 0; i < N_PLAT; i++) begin
        plat_x_q[i] <= 10'd320;
        plat_y_q[i] <= 10'((i + 1) * SPACING);
      end
    end else begin
      lfsr_q      <= lfsr_d;
      pix_on_q    <= pix_on_d;
      pix_idx_q   <= pix_idx_d;
      ball_land_q <= ball_land_d;
      land_idx_q  <= land_idx_d;
      for (int i = 0; i < N_PLAT; i++) begin
        plat_x_q[i] <= plat_x_d[i];
        plat_y_q[i] <= plat_y_d[i];
      end
    end
  end

  assign pix_on    = pix_on_q;
  assign pix_idx   = pix_idx_q;
  assign ball_land = ball_land_q;
  assign land_idx  = land_idx_q;
endmodule

// File: tb/tb_platform_field.sv
// Bench for platform_field: randomized layout/scroll traffic checked against a
// transaction-level playfield model with its own LFSR sequence.
`timescale 1ns/1ps
module tb_platform_field;
  localparam int N = 16, HW = 4, HH = 4, SP = 30, SH = 480, XMIN = 64;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       load_req = 1'b0, scroll_req = 1'b0;
  logic [3:0] scroll_amt = '0;
  logic [9:0] draw_x = '0, draw_y = '0, ball_x = '0, ball_y = '0, ball_size = '0;
  logic       busy, pix_on, ball_land;
  logic [3:0] pix_idx, land_idx;

  int n_cmp = 0, n_fail = 0;
  int edge_cnt;
  int mx[N];
  int my[N];

  platform_field dut (
    .Clk(clk), .Reset(rst_n), .load_req(load_req), .scroll_req(scroll_req),
    .scroll_amt(scroll_amt), .DrawX(draw_x), .DrawY(draw_y), .BallX(ball_x),
    .BallY(ball_y), .Ball_size(ball_size), .busy(busy), .pix_on(pix_on),
    .pix_idx(pix_idx), .ball_land(ball_land), .land_idx(land_idx)
  );

  always #5 clk = ~clk;

  // Rising edges seen since reset released; the LFSR has stepped this many times.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;

  function automatic int lfsr_at(input int n);
    logic [9:0] v;
    v = 10'h1A5;
    for (int i = 0; i < n; i++) v = {v[8:0], v[9] ^ v[6]};
    return int'(v);
  endfunction

  function automatic int new_x(input int n);
    return XMIN + (lfsr_at(n) % 512);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin mx[k] = 320; my[k] = (k + 1) * SP; end
  endtask

  task automatic model_load(input int c);
    for (int k = 0; k < N; k++) begin mx[k] = new_x(c + 1 + k); my[k] = (k + 1) * SP; end
  endtask

  task automatic model_scroll(input int c, input int amt);
    for (int k = 0; k < N; k++) begin
      if (my[k] + amt >= SH) begin my[k] = my[k] + amt - SH; mx[k] = new_x(c + 1 + k); end
      else my[k] = my[k] + amt;
    end
  endtask

  function automatic int model_pix(input int x, input int y);
    for (int k = 0; k < N; k++)
      if (x >= mx[k] - HW && x <= mx[k] + HW && y >= my[k] - HH && y <= my[k] + HH) return k;
    return -1;
  endfunction

  function automatic int model_land(input int bx, input int by, input int bs);
    int dx;
    for (int k = 0; k < N; k++) begin
      dx = (bx > mx[k]) ? bx - mx[k] : mx[k] - bx;
      if (by + bs >= my[k] - HH && by + bs <= my[k] + HH && dx <= HW + bs) return k;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_query(input int x, input int y, input int bx, input int by, input int bs,
                          output logic on, output logic [3:0] pidx,
                          output logic bl, output logic [3:0] lidx);
    draw_x = 10'(x); draw_y = 10'(y);
    ball_x = 10'(bx); ball_y = 10'(by); ball_size = 10'(bs);
    tick();
    on = pix_on; pidx = pix_idx; bl = ball_land; lidx = land_idx;
  endtask

  // Issues a request and returns the edge count at issue and the busy length.
  task automatic run_req(input logic ld, input logic sc, input int amt, input int inject_at,
                         output int c0, output int nbusy);
    c0 = edge_cnt;
    load_req = ld; scroll_req = sc; scroll_amt = 4'(amt);
    tick();
    load_req = 1'b0; scroll_req = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      nbusy++;
      if (i == inject_at) begin scroll_req = 1'b1; scroll_amt = 4'd9; end
      tick();
      scroll_req = 1'b0;
    end
  endtask

  task automatic test_layout_scan(input string tag);
    int px, py, e;
    logic on, bl; logic [3:0] pidx, lidx;
    for (int k = 0; k < N; k++) begin
      for (int p = 0; p < 5; p++) begin
        px = mx[k]; py = my[k];
        case (p)
          1: px = mx[k] - HW - 1;
          2: px = mx[k] + HW + 1;
          3: py = my[k] - HH - 1;
          4: py = my[k] + HH + 1;
          default: ;
        endcase
        if (py < 0 || py > 1023) continue;
        do_query(px, py, 0, 0, 0, on, pidx, bl, lidx);
        e = model_pix(px, py);
        n_cmp++;
        if (on !== (e >= 0) || pidx !== 4'((e >= 0) ? e : 0)) begin
          n_fail++;
          $display("FAIL %s scan k=%0d pt=(%0d,%0d): pix_on/idx got %0b/%0d want %0b/%0d",
                   tag, k, px, py, on, pidx, (e >= 0), (e >= 0) ? e : 0);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic on, bl; logic [3:0] pidx, lidx;
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({busy, pix_on, pix_idx, ball_land, land_idx} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want all zero", {busy, pix_on, pix_idx, ball_land, land_idx});
    end
    rst_n = 1'b1;
    model_reset();
    do_query(320, 30, 0, 0, 0, on, pidx, bl, lidx);
    n_cmp++;
    if (on !== 1'b1 || pidx !== 4'd0) begin
      n_fail++; $display("FAIL reset_hit_320_30: got %0b/%0d want 1/0", on, pidx);
    end
    do_query(325, 30, 0, 0, 0, on, pidx, bl, lidx);
    n_cmp++;
    if (on !== 1'b0) begin n_fail++; $display("FAIL reset_miss_325: got %0b want 0", on); end
    test_layout_scan("reset");
  endtask

  task automatic test_load();
    int c, nb;
    run_req(1'b1, 1'b0, 0, -1, c, nb);
    n_cmp++;
    if (nb !== N) begin n_fail++; $display("FAIL load_busy_len: got %0d want %0d", nb, N); end
    model_load(c);
    test_layout_scan("load");
  endtask

  task automatic test_scroll_twice();
    int c, nb;
    logic on, bl; logic [3:0] pidx, lidx;
    for (int r = 0; r < 2; r++) begin
      run_req(1'b0, 1'b1, 15, -1, c, nb);
      n_cmp++;
      if (nb !== N) begin n_fail++; $display("FAIL scroll%0d_busy_len: got %0d want %0d", r, nb, N); end
      model_scroll(c, 15);
      test_layout_scan("scroll15");
    end
    do_query(mx[0], 60, 0, 0, 0, on, pidx, bl, lidx);
    n_cmp++;
    if (on !== 1'b1 || pidx !== 4'd0) begin
      n_fail++; $display("FAIL plat0_at_60: got %0b/%0d want 1/0", on, pidx);
    end
    do_query(mx[15], 30, 0, 0, 0, on, pidx, bl, lidx);
    n_cmp++;
    if (on !== 1'b1 || pidx !== 4'd15) begin
      n_fail++; $display("FAIL plat15_at_30: got %0b/%0d want 1/15", on, pidx);
    end
  endtask

  task automatic test_both_and_busy();
    int c, nb;
    run_req(1'b1, 1'b1, 7, 3, c, nb);
    n_cmp++;
    if (nb !== N) begin n_fail++; $display("FAIL both_busy_len: got %0d want %0d", nb, N); end
    model_load(c);
    test_layout_scan("both");
  endtask

  task automatic test_boundary();
    int c, nb, cur, amt, e;
    logic on, bl; logic [3:0] pidx, lidx;
    run_req(1'b0, 1'b1, 0, -1, c, nb);
    model_scroll(c, 0);
    test_layout_scan("amt0");
    for (int it = 0; it < 80 && my[0] != 2; it++) begin
      cur = my[0];
      amt = (cur >= 467) ? 482 - cur : ((467 - cur > 15) ? 15 : 467 - cur);
      run_req(1'b0, 1'b1, amt, -1, c, nb);
      model_scroll(c, amt);
    end
    n_cmp++;
    if (my[0] != 2) begin n_fail++; $display("FAIL boundary_setup: plat0 y got %0d want 2", my[0]); end
    for (int p = 0; p < 4; p++) begin
      int ys[4] = '{0, 6, 7, 1020};
      do_query(mx[0], ys[p], 0, 0, 0, on, pidx, bl, lidx);
      e = model_pix(mx[0], ys[p]);
      n_cmp++;
      if (on !== (e >= 0) || pidx !== 4'((e >= 0) ? e : 0)) begin
        n_fail++;
        $display("FAIL boundary_y%0d: got %0b/%0d want %0b/%0d", ys[p], on, pidx, (e >= 0), (e >= 0) ? e : 0);
      end
    end
    test_layout_scan("boundary");
  endtask

  task automatic test_landing();
    logic on, bl; logic [3:0] pidx, lidx;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    model_reset();
    do_query(0, 0, 320, 26, 4, on, pidx, bl, lidx);
    n_cmp++;
    if (bl !== 1'b1 || lidx !== 4'd0) begin n_fail++; $display("FAIL land_a: got %0b/%0d want 1/0", bl, lidx); end
    do_query(0, 0, 329, 26, 4, on, pidx, bl, lidx);
    n_cmp++;
    if (bl !== 1'b0 || lidx !== 4'd0) begin n_fail++; $display("FAIL land_b: got %0b/%0d want 0/0", bl, lidx); end
    do_query(0, 0, 328, 56, 4, on, pidx, bl, lidx);
    n_cmp++;
    if (bl !== 1'b1 || lidx !== 4'd1) begin n_fail++; $display("FAIL land_edge: got %0b/%0d want 1/1", bl, lidx); end
  endtask

  task automatic test_random();
    int c, nb, k, x, y, bx, by, bs, ep, el;
    logic on, bl; logic [3:0] pidx, lidx;
    run_req(1'b1, 1'b0, 0, -1, c, nb);
    model_load(c);
    for (int r = 0; r < 3; r++) begin
      int amt = int'($urandom_range(1, 15));
      run_req(1'b0, 1'b1, amt, -1, c, nb);
      model_scroll(c, amt);
      for (int q = 0; q < 20; q++) begin
        k  = int'($urandom_range(0, N - 1));
        x  = mx[k] + int'($urandom_range(0, 12)) - 6;
        y  = my[k] + int'($urandom_range(0, 12)) - 6;
        bs = int'($urandom_range(0, 8));
        bx = mx[k] + int'($urandom_range(0, 28)) - 14;
        by = my[k] - bs + int'($urandom_range(0, 12)) - 6;
        if (y < 0) y = 0;
        if (by < 0) by = 0;
        do_query(x, y, bx, by, bs, on, pidx, bl, lidx);
        ep = model_pix(x, y);
        el = model_land(bx, by, bs);
        n_cmp++;
        if (on !== (ep >= 0) || pidx !== 4'((ep >= 0) ? ep : 0) ||
            bl !== (el >= 0) || lidx !== 4'((el >= 0) ? el : 0)) begin
          n_fail++;
          $display("FAIL random q=(%0d,%0d) ball=(%0d,%0d,%0d): pix %0b/%0d land %0b/%0d want pix %0b/%0d land %0b/%0d",
                   x, y, bx, by, bs, on, pidx, bl, lidx, (ep >= 0), (ep >= 0) ? ep : 0, (el >= 0), (el >= 0) ? el : 0);
        end
      end
    end
  endtask

  task automatic test_reset_mid_scroll();
    int c, nb;
    draw_x = 10'(mx[0]); draw_y = 10'(my[0]);
    scroll_req = 1'b1; scroll_amt = 4'(int'($urandom_range(1, 15)));
    tick();
    scroll_req = 1'b0;
    repeat (7) tick();
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midscroll_busy: got %0b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, pix_on, pix_idx, ball_land, land_idx} !== 11'd0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %b want all zero", {busy, pix_on, pix_idx, ball_land, land_idx});
    end
    tick();
    rst_n = 1'b1;
    model_reset();
    test_layout_scan("after_reset");
    run_req(1'b1, 1'b0, 0, -1, c, nb);
    n_cmp++;
    if (nb !== N) begin n_fail++; $display("FAIL post_reset_busy_len: got %0d want %0d", nb, N); end
    model_load(c);
    test_layout_scan("post_reset_load");
  endtask

  initial begin
    test_reset();
    test_load();
    test_scroll_twice();
    test_both_and_busy();
    test_boundary();
    test_landing();
    test_random();
    test_reset_mid_scroll();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
